// File: rtl/i2c_codec_cfg_responder.sv
// Write-only I2C target for codec configuration: {dev, {reg[6:0],d[8]}, d[7:0]} frames
// land in a small register file with a one-cycle write strobe and a frame counter.
module i2c_codec_cfg_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [6:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy,
  output logic [7:0] o_frame_cnt
);
  localparam int         AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREG = 8'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_t;

  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;
  logic oe_nxt, commit, shift_en, full;
  logic [2:0] cnt;
  logic [7:0] shreg, b1;
  logic [6:0] wa;
  logic [NUM_REGS-1:0][8:0] regs;

  // Sync flops idle high so reset release never fakes a bus edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync[0] <= i_scl;
      sda_sync[0] <= i_sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;
  assign shift_en = scl_rise && !full && (state inside {ADDR, BYTE1, BYTE2});
  assign wa       = b1[7:1];
  assign o_busy   = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oe_nxt    = o_sda_oe;
    commit    = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      oe_nxt    = 1'b0;
    end else if (start) begin
      state_nxt = ADDR;
      oe_nxt    = 1'b0;
    end else if (scl_fall) begin
      case (state)
        ADDR: if (full) begin
          if (shreg == {DEV_ADDR, 1'b0}) begin
            state_nxt = ACK_A;
            oe_nxt    = 1'b1;
          end else begin
            state_nxt = IGNORE;
            oe_nxt    = 1'b0;
          end
        end
        ACK_A: begin state_nxt = BYTE1; oe_nxt = 1'b0; end
        BYTE1: if (full) begin state_nxt = ACK_1; oe_nxt = 1'b1; end
        ACK_1: begin state_nxt = BYTE2; oe_nxt = 1'b0; end
        BYTE2: if (full) begin state_nxt = ACK_2; oe_nxt = 1'b1; end
        ACK_2: begin state_nxt = IGNORE; oe_nxt = 1'b0; commit = 1'b1; end
        default: ;
      endcase
    end
  end

  // shreg is left untouched through ACK_2, so it still holds byte2 at commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg    <= '0;
      b1       <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      o_sda_oe <= 1'b0;
    end else begin
      o_sda_oe <= oe_nxt;
      if (start || stop || (scl_fall && state_nxt != state)) begin
        cnt  <= '0;
        full <= 1'b0;
      end else if (shift_en) begin
        shreg <= {shreg[6:0], sda_s};
        cnt   <= cnt + 3'd1;
        full  <= (cnt == 3'd7);
      end
      if (state == BYTE1 && state_nxt == ACK_1) b1 <= shreg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_valid  <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_cnt <= '0;
      regs        <= '0;
    end else begin
      o_wr_valid <= commit;
      if (commit) begin
        o_wr_addr   <= wa;
        o_wr_data   <= {b1[0], shreg};
        o_frame_cnt <= o_frame_cnt + 8'd1;
        if ({1'b0, wa} < NREG) regs[wa[AW-1:0]] <= {b1[0], shreg};
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if ({1'b0, i_rd_addr} < NREG) o_rd_data = regs[i_rd_addr[AW-1:0]];
  end
endmodule

// File: tb/tb_i2c_codec_cfg_responder.sv
// Bit-banged I2C master driving the codec-config responder; checked against a frame-level model.
module tb_i2c_codec_cfg_responder;
  localparam int HP = 6;

  logic       clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  logic [6:0] rd_addr = '0;
  logic       sda_oe, wr_valid, busy;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;
  logic [7:0] frame_cnt;
  wire        sda_bus = m_sda & ~sda_oe;

  i2c_codec_cfg_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(m_scl), .i_sda(sda_bus),
    .o_sda_oe(sda_oe), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy), .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int pulses = 0, oe_cycles = 0;
  always @(negedge clk) begin
    if (wr_valid === 1'b1) pulses++;
    if (sda_oe === 1'b1) oe_cycles++;
  end

  // Frame-level reference: what the register file and output latches should hold.
  logic [8:0] mregs [128];
  logic [6:0] m_addr;
  logic [8:0] m_data;
  logic [7:0] m_cnt;
  int n_cmp = 0, n_bad = 0;

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) mregs[i] = '0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = '0;
  endfunction

  function automatic int model_frame(logic [7:0] dev, logic [7:0] b1, logic [7:0] b2);
    if (dev != 8'h34) return 0;
    m_addr = b1[7:1];
    m_data = {b1[0], b2};
    if (int'(m_addr) < 16) mregs[m_addr] = m_data;
    m_cnt = m_cnt + 8'd1;
    return 1;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; cyc(HP);
    m_scl = 1'b1; cyc(HP);
    m_sda = 1'b0; cyc(HP);
    m_scl = 1'b0; cyc(HP);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; cyc(HP);
    m_scl = 1'b1; cyc(HP);
    m_sda = 1'b1; cyc(2*HP);
  endtask

  task automatic send_bits(logic [7:0] b, int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; cyc(HP);
      m_scl = 1'b1; cyc(HP);
      m_scl = 1'b0;
    end
  endtask

  task automatic send_byte(logic [7:0] b, output bit ack);
    send_bits(b, 8);
    m_sda = 1'b1; cyc(HP);
    m_scl = 1'b1; cyc(HP/2);
    #1 ack = (sda_bus === 1'b0);
    cyc(HP - HP/2);
    m_scl = 1'b0;
  endtask

  task automatic do_frame(logic [7:0] dev, logic [7:0] b1, logic [7:0] b2, string nm);
    bit a0, a1, a2;
    int p0, o0, got, exp_p;
    p0 = pulses;
    o0 = oe_cycles;
    bus_start();
    send_byte(dev, a0); send_byte(b1, a1); send_byte(b2, a2);
    bus_stop();
    @(negedge clk);
    got   = int'(a0) + int'(a1) + int'(a2);
    exp_p = model_frame(dev, b1, b2);
    n_cmp++; if (got !== (exp_p != 0 ? 3 : 0)) begin n_bad++;
      $display("FAIL %s acks: got %0d want %0d", nm, got, (exp_p != 0 ? 3 : 0)); end
    n_cmp++; if (pulses - p0 !== exp_p) begin n_bad++;
      $display("FAIL %s strobe_cycles: got %0d want %0d", nm, pulses - p0, exp_p); end
    if (exp_p == 0) begin
      n_cmp++; if (oe_cycles !== o0) begin n_bad++;
        $display("FAIL %s sda_oe_driven: got %0d cycles want 0", nm, oe_cycles - o0); end
    end
    n_cmp++; if (wr_addr !== m_addr || wr_data !== m_data) begin n_bad++;
      $display("FAIL %s wr_addr/data: got %0h/%0h want %0h/%0h", nm, wr_addr, wr_data, m_addr, m_data); end
    n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++;
      $display("FAIL %s frame_cnt: got %0d want %0d", nm, frame_cnt, m_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL %s busy_after_stop: got %b want 0", nm, busy); end
  endtask

  task automatic test_regfile(string nm);
    logic [8:0] exp;
    for (int a = 0; a < 128; a++) begin
      rd_addr = 7'(a);
      #1;
      exp = (a < 16) ? mregs[a] : 9'd0;
      n_cmp++; if (rd_data !== exp) begin n_bad++;
        $display("FAIL %s rd_data[%0d]: got %0h want %0h", nm, a, rd_data, exp); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({sda_oe, wr_valid, busy} !== 3'b000) begin n_bad++;
      $display("FAIL reset oe/valid/busy: got %b want 000", {sda_oe, wr_valid, busy}); end
    n_cmp++; if (wr_addr !== 7'd0 || wr_data !== 9'd0 || frame_cnt !== 8'd0) begin n_bad++;
      $display("FAIL reset addr/data/cnt: got %0h/%0h/%0h want 0/0/0", wr_addr, wr_data, frame_cnt); end
    test_regfile("reset");
  endtask

  task automatic test_basic();
    do_frame(8'h34, 8'h08, 8'h15, "basic");
    n_cmp++; if (wr_addr !== 7'd4 || wr_data !== 9'h015) begin n_bad++;
      $display("FAIL basic_const addr/data: got %0h/%0h want 4/15", wr_addr, wr_data); end
    test_regfile("basic");
  endtask

  task automatic test_boundary();
    do_frame(8'h34, 8'h1F, 8'hFF, "top_reg");
    n_cmp++; if (wr_addr !== 7'd15 || wr_data !== 9'h1FF) begin n_bad++;
      $display("FAIL top_reg_const addr/data: got %0h/%0h want f/1ff", wr_addr, wr_data); end
    do_frame(8'h34, 8'h1E, 8'h00, "top_reg_clr");
    do_frame(8'h34, 8'h20, 8'hAB, "out_of_range");
    test_regfile("boundary");
  endtask

  task automatic test_foreign();
    do_frame(8'h36, 8'h08, 8'h55, "other_dev");
    do_frame(8'h35, 8'h0A, 8'h77, "read_req");
    test_regfile("foreign");
  endtask

  task automatic test_abort();
    bit a;
    int p0;
    p0 = pulses;
    bus_start(); send_byte(8'h34, a); send_byte(8'h08, a); bus_stop();
    @(negedge clk);
    n_cmp++; if (pulses !== p0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL stop_abort strobes/busy: got %0d/%b want 0/0", pulses - p0, busy); end
    bus_start(); send_byte(8'h34, a); send_byte(8'h12, a); send_bits(8'h34, 4);
    do_frame(8'h34, 8'h12, 8'h34, "rstart");
    n_cmp++; if (pulses - p0 !== 1 || wr_addr !== 7'd9 || wr_data !== 9'h034) begin n_bad++;
      $display("FAIL rstart_total strobes/addr/data: got %0d/%0h/%0h want 1/9/34", pulses - p0, wr_addr, wr_data); end
    test_regfile("abort");
  endtask

  task automatic test_random();
    logic [7:0] dev;
    int r;
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      dev = (r < 7) ? 8'h34 : (r == 7) ? 8'h35 : (r == 8) ? 8'h36 : 8'($urandom);
      do_frame(dev, 8'($urandom), 8'($urandom), "random");
    end
    test_regfile("random");
  endtask

  task automatic test_reset_mid();
    bit a;
    logic [7:0] init_b1 [7] = '{8'h1E, 8'h0C, 8'h0E, 8'h10, 8'h08, 8'h0A, 8'h12};
    logic [7:0] init_b2 [7] = '{8'h00, 8'h00, 8'h42, 8'h00, 8'h12, 8'h00, 8'h01};
    bus_start(); send_byte(8'h34, a); send_byte(8'h08, a); send_bits(8'h15, 3);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL mid_frame busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({sda_oe, busy, wr_valid} !== 3'b000 || frame_cnt !== 8'd0) begin n_bad++;
      $display("FAIL rst_mid oe/busy/valid cnt: got %b %0d want 000 0", {sda_oe, busy, wr_valid}, frame_cnt); end
    test_regfile("rst_mid");
    m_sda = 1'b1; cyc(HP);
    m_scl = 1'b1; cyc(HP);
    rst_n = 1'b1; cyc(4);
    for (int k = 0; k < 7; k++) do_frame(8'h34, init_b1[k], init_b2[k], "init_seq");
    n_cmp++; if (frame_cnt !== 8'd7) begin n_bad++;
      $display("FAIL init_seq cnt: got %0d want 7", frame_cnt); end
    test_regfile("init_seq");
  endtask

  initial begin
    model_reset();
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    test_reset();
    test_basic();
    test_boundary();
    test_foreign();
    test_abort();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
